// File: rtl/regs_pkg.sv
// Shared definitions for the register-file writeback path.
//   XLEN           register data width
//   REG_AW         register address width
//   ZERO_REG_ADDR  address of the hardwired zero register (writes to it are dropped)
//   wb_req_t       one writeback: destination register plus data
package regs_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] ZERO_REG_ADDR = '0;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/regs_write_arbiter_if.sv
// Bundle between the writeback sources, the regfile write port and decode.
//   req_valid/req_ready/req_rd/req_wdata  per-requester handshake, slice i = requester i
//   w_en/rd/rd_wdata                      registered regfile write port
//   rs1/rs2, rs1_pending/rs2_pending      decode-stage hazard query
// The master modport is the environment (requesters, regfile, decode);
// the slave modport is the arbiter.
interface regs_write_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int AW      = 5
);

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*AW-1:0]   req_rd;
  logic [NUM_REQ*XLEN-1:0] req_wdata;

  logic                    w_en;
  logic [AW-1:0]           rd;
  logic [XLEN-1:0]         rd_wdata;

  logic [AW-1:0]           rs1;
  logic [AW-1:0]           rs2;
  logic                    rs1_pending;
  logic                    rs2_pending;

  modport master (
    output req_valid, req_rd, req_wdata, rs1, rs2,
    input  req_ready, w_en, rd, rd_wdata, rs1_pending, rs2_pending
  );

  modport slave (
    input  req_valid, req_rd, req_wdata, rs1, rs2,
    output req_ready, w_en, rd, rd_wdata, rs1_pending, rs2_pending
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req    requests, one bit per source
//   ptr    highest-priority index for this cycle
//   grant  one-hot grant (all zero when no request)
//   idx    binary index of the granted source (0 when no request)
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Scan N positions starting at ptr, wrapping modulo N; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      pos = sum[IW-1:0];
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/regs_write_arbiter.sv
// Shares the regfile's single write port among NUM_REQ writeback sources.
// Each source owns a one-entry holding buffer; a round-robin scheduler drains
// one buffer per cycle onto the registered write port, and decode can ask
// whether a source register still has a write in flight.
//   clk, rst_n  clock, async active-low reset (discards buffered writes)
//   bus         regs_write_arbiter_if.slave: requester handshakes, regfile
//               write port (w_en/rd/rd_wdata) and rs1/rs2 pending flags
module regs_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = regs_pkg::XLEN,
  parameter int AW      = regs_pkg::REG_AW
) (
  input logic                  clk,
  input logic                  rst_n,
  regs_write_arbiter_if.slave  bus
);

  import regs_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [AW-1:0] ZERO_RD = AW'(ZERO_REG_ADDR);

  logic [NUM_REQ-1:0] buf_valid;
  logic [AW-1:0]      buf_rd   [NUM_REQ];
  logic [XLEN-1:0]    buf_data [NUM_REQ];
  logic [IW-1:0]      rr_ptr;

  logic               w_en_q;
  logic [AW-1:0]      rd_q;
  logic [XLEN-1:0]    rd_wdata_q;

  logic [AW-1:0]      req_rd_a    [NUM_REQ];
  logic [XLEN-1:0]    req_wdata_a [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic [NUM_REQ-1:0] conflict;
  logic [NUM_REQ-1:0] ready;
  logic               rs1_hit;
  logic               rs2_hit;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rd_a[i]    = bus.req_rd[i*AW +: AW];
      req_wdata_a[i] = bus.req_wdata[i*XLEN +: XLEN];
    end
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req   (buf_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  // A new write to register r must wait while an older write to r sits in a
  // buffer that is not draining this cycle, or while a lower-index source
  // offers r in the same cycle. This keeps per-register write order.
  // A granted buffer leaves this edge, so anything accepted now lands after it.
  always_comb begin
    conflict = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_rd_a[i] != ZERO_RD) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (buf_valid[j] && !grant[j] && (buf_rd[j] == req_rd_a[i])) begin
            conflict[i] = 1'b1;
          end
        end
        for (int k = 0; k < i; k++) begin
          if (bus.req_valid[k] && (req_rd_a[k] == req_rd_a[i])) begin
            conflict[i] = 1'b1;
          end
        end
      end
    end
  end

  assign ready         = (~buf_valid | grant) & ~conflict;
  assign bus.req_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid  <= '0;
      rr_ptr     <= '0;
      w_en_q     <= 1'b0;
      rd_q       <= '0;
      rd_wdata_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_rd[i]   <= '0;
        buf_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          buf_valid[i] <= 1'b0;
        end
        // Writes to the zero register are handshaken but never buffered.
        if (bus.req_valid[i] && ready[i] && (req_rd_a[i] != ZERO_RD)) begin
          buf_valid[i] <= 1'b1;
          buf_rd[i]    <= req_rd_a[i];
          buf_data[i]  <= req_wdata_a[i];
        end
      end

      if (|grant) begin
        w_en_q     <= 1'b1;
        rd_q       <= buf_rd[grant_idx];
        rd_wdata_q <= buf_data[grant_idx];
        rr_ptr     <= (grant_idx == IW'(NUM_REQ-1)) ? '0 : grant_idx + IW'(1);
      end else begin
        w_en_q     <= 1'b0;
      end
    end
  end

  assign bus.w_en     = w_en_q;
  assign bus.rd       = rd_q;
  assign bus.rd_wdata = rd_wdata_q;

  // A register is pending while its write is buffered or on the write port
  // this cycle (the regfile takes it at the next edge).
  always_comb begin
    rs1_hit = w_en_q && (rd_q == bus.rs1);
    rs2_hit = w_en_q && (rd_q == bus.rs2);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (buf_valid[i] && (buf_rd[i] == bus.rs1)) begin
        rs1_hit = 1'b1;
      end
      if (buf_valid[i] && (buf_rd[i] == bus.rs2)) begin
        rs2_hit = 1'b1;
      end
    end
  end

  assign bus.rs1_pending = (bus.rs1 != ZERO_RD) && rs1_hit;
  assign bus.rs2_pending = (bus.rs2 != ZERO_RD) && rs2_hit;

endmodule

// File: tb/tb_regs_write_arbiter.sv
module tb_regs_write_arbiter;
  import regs_pkg::*;

  localparam int NR = 2;
  localparam int XW = 32;
  localparam int AWID = 5;

  logic clk;
  logic rst_n;

  int n_chk;
  int n_err;

  wb_req_t exp_q[$];
  wb_req_t q0[$];
  wb_req_t q1[$];
  logic [1:0] rdy_smp;

  regs_write_arbiter_if #(.NUM_REQ(NR), .XLEN(XW), .AW(AWID)) bus ();

  regs_write_arbiter #(.NUM_REQ(NR), .XLEN(XW), .AW(AWID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic wb_req_t mk(input logic [4:0] r, input logic [31:0] d);
    wb_req_t w;
    w.rd   = r;
    w.data = d;
    return w;
  endfunction

  task automatic drive();
    if (q0.size() > 0) begin
      bus.req_valid[0]      = 1'b1;
      bus.req_rd[4:0]       = q0[0].rd;
      bus.req_wdata[31:0]   = q0[0].data;
    end else begin
      bus.req_valid[0]      = 1'b0;
    end
    if (q1.size() > 0) begin
      bus.req_valid[1]      = 1'b1;
      bus.req_rd[9:5]       = q1[0].rd;
      bus.req_wdata[63:32]  = q1[0].data;
    end else begin
      bus.req_valid[1]      = 1'b0;
    end
  endtask

  // One clock: offer the heads of q0/q1, note the handshake before the edge,
  // retire accepted heads, end #1 after the edge with inputs re-driven.
  task automatic cycle();
    logic [1:0] acc;
    drive();
    @(negedge clk);
    rdy_smp = bus.req_ready;
    acc     = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    drive();
  endtask

  // Write-port scoreboard: every regfile write must be the next expected one.
  initial begin
    wb_req_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b1 && bus.w_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_wen", 64'(bus.rd), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wr_rd", 64'(bus.rd), 64'(e.rd));
          check("wr_data", 64'(bus.rd_wdata), 64'(e.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    bus.req_valid = '0;
    bus.req_rd    = '0;
    bus.req_wdata = '0;
    bus.rs1       = 5'd3;
    bus.rs2       = 5'd4;
    rst_n         = 1'b0;

    // Reset values
    #3;
    check("rst_wen", 64'(bus.w_en), 64'(0));
    check("rst_rd", 64'(bus.rd), 64'(0));
    check("rst_wdata", 64'(bus.rd_wdata), 64'(0));
    check("rst_rs1p", 64'(bus.rs1_pending), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill both buffers, then reset before either drains
    q0.push_back(mk(5'd3, 32'h0000_0333));
    q1.push_back(mk(5'd4, 32'h0000_0444));
    cycle();
    check("fill_rs1p", 64'(bus.rs1_pending), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst2_wen", 64'(bus.w_en), 64'(0));
    check("rst2_rd", 64'(bus.rd), 64'(0));
    check("rst2_wdata", 64'(bus.rd_wdata), 64'(0));
    check("rst2_rs1p", 64'(bus.rs1_pending), 64'(0));
    check("rst2_rs2p", 64'(bus.rs2_pending), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst2_ready", 64'(bus.req_ready), 64'(2'b11));
    repeat (3) cycle();

    // Single write from requester 0
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd6;
    #1;
    check("single_pre_rs1p", 64'(bus.rs1_pending), 64'(0));
    q0.push_back(mk(5'd5, 32'hDEAD_BEEF));
    exp_q.push_back(mk(5'd5, 32'hDEAD_BEEF));
    cycle();
    check("single_ready", 64'(rdy_smp[0]), 64'(1));
    check("single_n_wen", 64'(bus.w_en), 64'(0));
    check("single_n_rs1p", 64'(bus.rs1_pending), 64'(1));
    check("single_n_rs2p", 64'(bus.rs2_pending), 64'(0));
    cycle();
    check("single_n1_wen", 64'(bus.w_en), 64'(1));
    check("single_n1_rs1p", 64'(bus.rs1_pending), 64'(1));
    cycle();
    check("single_n2_wen", 64'(bus.w_en), 64'(0));
    check("single_n2_rs1p", 64'(bus.rs1_pending), 64'(0));
    check("single_n2_rd_hold", 64'(bus.rd), 64'(5));

    // Round robin: last grant went to requester 0, so requester 1 drains first
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(5'(8 + i), 32'hA000_0000 + 32'(i)));
      q1.push_back(mk(5'(16 + i), 32'hB000_0000 + 32'(i)));
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk(5'(16 + i), 32'hB000_0000 + 32'(i)));
      exp_q.push_back(mk(5'(8 + i), 32'hA000_0000 + 32'(i)));
    end
    cycle();
    check("rr_ready_c0", 64'(rdy_smp), 64'(2'b11));
    for (int k = 1; k <= 8; k++) begin
      cycle();
      if (k <= 4) check("rr_ready", 64'(rdy_smp), (k % 2 == 1) ? 64'(2'b10) : 64'(2'b01));
      check("rr_wen_high", 64'(bus.w_en), 64'(1));
    end
    cycle();
    check("rr_wen_done", 64'(bus.w_en), 64'(0));

    // Same destination from both requesters in one cycle
    q0.push_back(mk(5'd7, 32'd1));
    q1.push_back(mk(5'd7, 32'd2));
    exp_q.push_back(mk(5'd7, 32'd1));
    exp_q.push_back(mk(5'd7, 32'd2));
    cycle();
    check("same_rd_ready", 64'(rdy_smp), 64'(2'b01));
    cycle();
    check("same_rd_ready1", 64'(rdy_smp[1]), 64'(1));
    repeat (3) cycle();
    check("same_rd_idle", 64'(bus.w_en), 64'(0));

    // Writes to x0 are accepted and dropped
    bus.rs1 = 5'd0;
    q1.push_back(mk(5'd0, 32'h55));
    cycle();
    check("x0_ready", 64'(rdy_smp[1]), 64'(1));
    check("x0_rs1p", 64'(bus.rs1_pending), 64'(0));
    cycle();
    check("x0_wen_n1", 64'(bus.w_en), 64'(0));
    cycle();
    check("x0_wen_n2", 64'(bus.w_en), 64'(0));

    // Reset while buffer 1 holds a write
    bus.rs1 = 5'd9;
    q1.push_back(mk(5'd9, 32'h99));
    cycle();
    check("mid_rs1p_before", 64'(bus.rs1_pending), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rs1p_rst", 64'(bus.rs1_pending), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("mid_no_wen", 64'(bus.w_en), 64'(0));
    end

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
